// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and helpers for the UART word arbiter
package uart_arb_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;
  localparam int DATA_W_DEF = 48;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin selector, first valid requester after rr_ptr with wrap-around
module rr_pick #(
  parameter int N = 3,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] rr_ptr,
  output logic            any_valid,
  output logic [ID_W-1:0] winner,
  output logic [N-1:0]    grant
);
  localparam int SW = ID_W + 1;
  logic [SW-1:0] start, sum;
  logic [N-1:0] rot;
  assign any_valid = |req;
  assign start = {1'b0, rr_ptr} + SW'(1);
  assign rot = N'({req, req} >> start);
  // lowest set bit of the rotated request vector wins; map it back to an absolute index
  always_comb begin
    sum = '0;
    for (int j = N - 1; j >= 0; j--)
      if (rot[j]) sum = start + SW'(j);
    winner = ID_W'(sum >= SW'(N) ? sum - SW'(N) : sum);
  end
  assign grant = any_valid ? N'(1) << winner : '0;
endmodule

// File: rtl/uart_word_arbiter.sv
// uart_word_arbiter: round-robin sharing of one UART word transmitter among NUM_REQ producers
module uart_word_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W = DATA_W_DEF,
  parameter int GAP_CYC = 0,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        uart_start,
  output logic [DATA_W-1:0]           uart_data,
  input  logic                        trans_done,
  output logic                        busy,
  output logic [id_w(NUM_REQ)-1:0]    grant_id,
  output logic                        word_done,
  output logic                        err_timeout
);
  localparam int ID_W = id_w(NUM_REQ);
  localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
  localparam int WW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  state_t state;
  logic [ID_W-1:0] rr_ptr, winner;
  logic [NUM_REQ-1:0] grant;
  logic any_valid, expire;
  logic [GW-1:0] gap_cnt;
  logic [WW-1:0] wd_cnt;
  logic [DATA_W-1:0] words [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
    assign words[g] = req_data[g*DATA_W +: DATA_W];
  end
  rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req(req_valid),
    .rr_ptr(rr_ptr),
    .any_valid(any_valid),
    .winner(winner),
    .grant(grant)
  );
  assign req_ready = (state == IDLE) ? grant : '0;
  assign expire = (TIMEOUT_CYC > 0) && (wd_cnt == WW'(TIMEOUT_CYC - 1));
  // grant, launch, wait for completion or watchdog, then optional idle gap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= ID_W'(NUM_REQ - 1);
      uart_data <= '0;
      grant_id <= '0;
      uart_start <= 1'b0;
      busy <= 1'b0;
      word_done <= 1'b0;
      err_timeout <= 1'b0;
      gap_cnt <= '0;
      wd_cnt <= '0;
    end else begin
      uart_start <= 1'b0;
      word_done <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: if (any_valid) begin
          state <= LAUNCH;
          uart_data <= words[winner];
          grant_id <= winner;
          rr_ptr <= winner;
          uart_start <= 1'b1;
          busy <= 1'b1;
        end
        LAUNCH: begin
          state <= WAIT;
          wd_cnt <= '0;
        end
        WAIT: begin
          wd_cnt <= wd_cnt + WW'(1);
          if (trans_done || expire) begin
            word_done <= trans_done;
            err_timeout <= !trans_done;
            state <= (GAP_CYC > 0) ? GAP : IDLE;
            busy <= GAP_CYC > 0;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          if (gap_cnt == GW'(GAP_CYC - 1)) begin
            state <= IDLE;
            busy <= 1'b0;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_uart_word_arbiter.sv
// tb_uart_word_arbiter: directed and randomized checks of two arbiter configurations against a reference model
module tb_uart_word_arbiter;
  localparam int GP [2] = '{0, 5};
  localparam int TO [2] = '{0, 20};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] valid [2];
  logic [143:0] data [2];
  logic td [2];
  logic [2:0] ready [2];
  logic start [2], busy [2], wdone [2], terr [2];
  logic [47:0] udata [2];
  logic [1:0] gid [2];
  int checks = 0, errors = 0;
  bit m_active [2], m_done [2], m_err [2];
  int m_age [2], m_gap [2], m_last [2], m_gid [2], pk [2], cnt [2];
  logic [47:0] m_word [2];
  logic [2:0] taken [2];
  logic [47:0] rrw [3];
  always #5 clk = ~clk;
  uart_word_arbiter #(.NUM_REQ(3), .DATA_W(48), .GAP_CYC(0), .TIMEOUT_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid[0]), .req_data(data[0]), .req_ready(ready[0]),
    .uart_start(start[0]), .uart_data(udata[0]), .trans_done(td[0]), .busy(busy[0]),
    .grant_id(gid[0]), .word_done(wdone[0]), .err_timeout(terr[0])
  );
  uart_word_arbiter #(.NUM_REQ(3), .DATA_W(48), .GAP_CYC(5), .TIMEOUT_CYC(20)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid[1]), .req_data(data[1]), .req_ready(ready[1]),
    .uart_start(start[1]), .uart_data(udata[1]), .trans_done(td[1]), .busy(busy[1]),
    .grant_id(gid[1]), .word_done(wdone[1]), .err_timeout(terr[1])
  );
  function automatic int pick(input logic [2:0] v, input int last);
    int i;
    for (int k = 1; k <= 3; k++) begin
      i = (last + k) % 3;
      if (v[i[1:0]]) return i;
    end
    return -1;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_start(input int d, input int lim);
    int n = 0;
    while (start[d] !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("d%0d_start_seen", d), start[d], 1);
  endtask
  always_comb
    for (int d = 0; d < 2; d++) pk[d] = pick(valid[d], m_last[d]);
  // reference model: a word is in flight for `age` cycles after its grant, then GP idle cycles follow
  always @(posedge clk or negedge rst_n)
    for (int d = 0; d < 2; d++)
      if (!rst_n) begin
        m_active[d] <= 1'b0;
        m_age[d] <= 0;
        m_gap[d] <= 0;
        m_last[d] <= 2;
        m_gid[d] <= 0;
        m_word[d] <= '0;
        m_done[d] <= 1'b0;
        m_err[d] <= 1'b0;
      end else begin
        m_done[d] <= 1'b0;
        m_err[d] <= 1'b0;
        if (m_active[d]) begin
          if (m_age[d] >= 1 && td[d]) begin
            m_done[d] <= 1'b1;
            m_active[d] <= 1'b0;
            m_gap[d] <= GP[d];
          end else if (TO[d] > 0 && m_age[d] == TO[d]) begin
            m_err[d] <= 1'b1;
            m_active[d] <= 1'b0;
            m_gap[d] <= GP[d];
          end else m_age[d] <= m_age[d] + 1;
        end else if (m_gap[d] > 0) m_gap[d] <= m_gap[d] - 1;
        else if (pk[d] >= 0) begin
          m_active[d] <= 1'b1;
          m_age[d] <= 0;
          m_gid[d] <= pk[d];
          m_last[d] <= pk[d];
          m_word[d] <= 48'(data[d] >> (48 * pk[d]));
        end
      end
  // every cycle, every output of both instances against the model
  always @(negedge clk)
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_ready", d), ready[d],
          (m_active[d] || m_gap[d] > 0 || pk[d] < 0) ? 3'b000 : 3'(1 << pk[d]));
      chk($sformatf("d%0d_busy", d), busy[d], m_active[d] || m_gap[d] > 0);
      chk($sformatf("d%0d_start", d), start[d], m_active[d] && m_age[d] == 0);
      chk($sformatf("d%0d_data", d), udata[d], m_word[d]);
      chk($sformatf("d%0d_gid", d), gid[d], m_gid[d]);
      chk($sformatf("d%0d_done", d), wdone[d], m_done[d]);
      chk($sformatf("d%0d_err", d), terr[d], m_err[d]);
    end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    for (int d = 0; d < 2; d++) begin
      valid[d] = '0;
      data[d] = '0;
      td[d] = 1'b0;
      cnt[d] = 0;
      taken[d] = '0;
    end
    rrw[0] = 48'h0123_4567_89AB;
    rrw[1] = 48'h2222_1111_0000;
    rrw[2] = 48'h3333_4444_5555;
    step(2);
    @(negedge clk);
    chk("rst_busy", busy[0], 0);
    chk("rst_start", start[0], 0);
    chk("rst_ready", ready[0], 0);
    chk("rst_data", udata[0], 0);
    chk("rst_gid", gid[0], 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    data[0][47:0] = 48'h8000_00AB_CDEF;
    valid[0] = 3'b001;
    @(negedge clk);
    chk("t1_ready", ready[0], 3'b001);
    step(1);
    valid[0] = 3'b000;
    @(negedge clk);
    chk("t1_start", start[0], 1);
    chk("t1_data", udata[0], 48'h8000_00AB_CDEF);
    chk("t1_ready_off", ready[0], 0);
    step(100);
    td[0] = 1'b1;
    step(1);
    td[0] = 1'b0;
    @(negedge clk);
    chk("t1_word_done", wdone[0], 1);
    chk("t1_busy_low", busy[0], 0);
    chk("t1_data_hold", udata[0], 48'h8000_00AB_CDEF);
    step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    data[0] = {rrw[2], rrw[1], rrw[0]};
    valid[0] = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_start(0, 20);
      chk("rr_order", gid[0], k % 3);
      chk("rr_word", udata[0], rrw[k % 3]);
      step(10);
      td[0] = 1'b1;
      step(1);
      td[0] = 1'b0;
    end
    valid[0] = 3'b000;
    data[1] = {48'hCCCC_0000_0002, 48'hBBBB_0000_0001, 48'hAAAA_0000_0000};
    valid[1] = 3'b110;
    wait_start(1, 20);
    chk("gap_first_gid", gid[1], 1);
    #1 valid[1][1] = 1'b0;
    step(3);
    td[1] = 1'b1;
    step(1);
    td[1] = 1'b0;
    @(negedge clk);
    chk("gap_word_done", wdone[1], 1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("gap_busy", busy[1], 1);
      chk("gap_no_ready", ready[1], 0);
      step(1);
    end
    @(negedge clk);
    chk("gap_idle", busy[1], 0);
    chk("gap_ready_after", ready[1], 3'b100);
    wait_start(1, 5);
    #1 valid[1] = 3'b000;
    step(2);
    td[1] = 1'b1;
    step(1);
    td[1] = 1'b0;
    step(6);
    valid[1] = 3'b011;
    wait_start(1, 20);
    chk("to_first_gid", gid[1], 0);
    #1 valid[1][0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      @(negedge clk);
      chk("to_quiet", terr[1] | wdone[1], 0);
    end
    step(1);
    @(negedge clk);
    chk("to_err", terr[1], 1);
    chk("to_no_done", wdone[1], 0);
    wait_start(1, 12);
    chk("to_next_gid", gid[1], 1);
    #1 valid[1] = 3'b000;
    step(20);
    td[1] = 1'b1;
    step(1);
    td[1] = 1'b0;
    @(negedge clk);
    chk("tie_done", wdone[1], 1);
    chk("tie_no_err", terr[1], 0);
    step(7);
    data[0][47:0] = 48'h5A5A_5A5A_5A5A;
    valid[0] = 3'b001;
    wait_start(0, 10);
    #1 valid[0] = 3'b000;
    step(3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy[0], 0);
    chk("rst_mid_data", udata[0], 0);
    chk("rst_mid_gid", gid[0], 0);
    chk("rst_mid_start", start[0], 0);
    chk("rst_mid_busy1", busy[1], 0);
    chk("rst_mid_data1", udata[1], 0);
    step(1);
    rst_n = 1'b1;
    valid[0] = 3'b111;
    @(negedge clk);
    chk("rst_first_ready", ready[0], 3'b001);
    wait_start(0, 5);
    chk("rst_first_gid", gid[0], 0);
    step(2);
    valid[0][1] = 1'b0;
    step(3);
    td[0] = 1'b1;
    step(1);
    td[0] = 1'b0;
    wait_start(0, 5);
    chk("withdraw_gid", gid[0], 2);
    #1 valid[0] = 3'b000;
    step(2);
    td[0] = 1'b1;
    step(1);
    td[0] = 1'b0;
    step(8);
    repeat (3000) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        taken[d] = valid[d] & ready[d];
        if (start[d])
          cnt[d] = (d == 1 && $urandom_range(3) == 0) ? 0 : 1 + $urandom_range(d == 1 ? 24 : 14);
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 3; i++)
          if (taken[d][i]) valid[d][i] = 1'b0;
          else if (!valid[d][i] && $urandom_range(3) == 0) begin
            valid[d][i] = 1'b1;
            data[d][i*48 +: 48] = {16'($urandom), $urandom};
          end else if (valid[d][i] && $urandom_range(39) == 0) valid[d][i] = 1'b0;
        td[d] = (cnt[d] == 1) || ($urandom_range(49) == 0);
        if (cnt[d] > 0) cnt[d]--;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_word_arbiter.md
Name: uart_word_arbiter

Overview:
- Shares the single 48-bit UART word transmitter between up to NUM_REQ producers, e.g. the cos/sin result path, a status reporter and a debug dumper.
- Each producer offers one 48-bit word with a valid/ready handshake. The arbiter grants round-robin, launches the transmitter with a one-cycle start pulse, and waits for its trans_done.
- Enforces an optional inter-word gap and recovers from a missing trans_done via a watchdog.
- Sits between the producers and the UART transmitter, which is reset by the same rst_n.

Parameters:
- NUM_REQ, 3, number of requesters (1..8)
- DATA_W, 48, word width sent per UART transaction
- GAP_CYC, 0, idle clk cycles enforced after each trans_done before the next grant (0 = none)
- TIMEOUT_CYC, 0, max clk cycles waiting for trans_done (0 = watchdog disabled)
- ID_W (derived), max(1, clog2(NUM_REQ))

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- uart_start  out  1  one-cycle start pulse to the transmitter
- uart_data  out  DATA_W  word to transmitter; held stable from start until trans_done
- trans_done  in  1  transmitter completion pulse
- busy  out  1  high in any state other than IDLE
- grant_id  out  ID_W  index of the requester currently being served
- word_done  out  1  one-cycle pulse when a word completes normally
- err_timeout  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset values: state IDLE; req_ready=0; uart_start=0; uart_data=0; busy=0; grant_id=0; word_done=0; err_timeout=0; rr_ptr=NUM_REQ-1, so requester 0 wins first; gap and watchdog counters 0.
- Reset mid-operation: the in-flight word is abandoned; no done or error pulse is issued.
- States: IDLE, LAUNCH, WAIT, GAP.
- IDLE:
  - winner = first i with req_valid[i], searching rr_ptr+1, rr_ptr+2, ... with wrap-around modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; only the winner sees ready.
  - The transfer happens when valid&ready. On that edge: latch req_data slice into uart_data, grant_id<=winner, rr_ptr<=winner, go LAUNCH.
  - With no valid requester, stay in IDLE.
- LAUNCH: uart_start=1 for exactly this one cycle; go WAIT. trans_done is ignored in this cycle.
- WAIT:
  - On trans_done: word_done pulses next cycle. Go GAP if GAP_CYC>0, else IDLE.
  - Watchdog: counter increments each WAIT cycle. If TIMEOUT_CYC>0 and the counter reaches TIMEOUT_CYC-1 without trans_done, pulse err_timeout next cycle, do not pulse word_done, and go GAP or IDLE as above.
  - If trans_done and the watchdog expiry fall on the same cycle, trans_done wins.
- GAP: count GAP_CYC cycles, then go IDLE. trans_done seen in GAP or IDLE is ignored.
- Handshake rules: requesters must hold req_valid and data until ready. Dropping valid before ready is legal and no word is taken. req_ready is never asserted outside IDLE.
- Throughput: with GAP_CYC=0, minimum 3 cycles per word plus UART time. Back-to-back: the IDLE grant occurs the cycle after leaving WAIT.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 words.
- uart_data and grant_id hold their values after completion until the next grant.

Decomposition:
- Package uart_arb_pkg:
  - state enum (IDLE, LAUNCH, WAIT, GAP)
  - DATA_W default constant 48
  - helper function for ID_W
- Sub-module rr_pick:
  - combinational round-robin selector
  - inputs: req vector, rr_ptr
  - outputs: any_valid, winner index, one-hot grant
- The state machine, counters and data register stay in uart_word_arbiter.

Test Plan:
- Single request: req_valid=3'b001, data 48'h800000ABCDEF → req_ready=001 for 1 cycle, uart_start pulse the next cycle with uart_data=48'h800000ABCDEF. trans_done 100 cycles later → word_done pulse, busy falls.
- Round-robin: all three valid continuously, each trans_done returned 10 cycles after start → grant order 0,1,2,0,1,2. No requester is ever granted twice in a row.
- Gap: GAP_CYC=5 → exactly 5 cycles from the cycle after trans_done to re-entering IDLE. No req_ready during the gap.
- Timeout: TIMEOUT_CYC=20, trans_done never asserted → err_timeout pulse 20 cycles after entering WAIT, no word_done, next requester granted. trans_done arriving in the same cycle as expiry → word_done only.
- Reset mid-WAIT: assert rst_n low while busy → all outputs return to reset values immediately. After release, requester 0 is granted first.
- Valid withdrawn: requester 1 drops valid during requester 0's WAIT → requester 1 is not granted; requester 2 is granted next.
